// File: rtl/multitap_pkg.sv
// Shared types, ASCII constants and key-table helpers for the multi-tap encoder.
package multitap_pkg;

  typedef enum logic [0:0] {StIdle, StCompose} state_e;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_SP = 8'h20;

  function automatic logic [7:0] key_char(input logic [3:0] key_idx, input logic [1:0] tap);
    logic [7:0] base;
    base = 8'h00;
    unique case (key_idx)
      4'd0: base = 8'h41;
      4'd1: base = 8'h44;
      4'd2: base = 8'h47;
      4'd3: base = 8'h4A;
      4'd4: base = 8'h4D;
      4'd5: base = 8'h50;
      4'd6: base = 8'h54;
      4'd7: base = 8'h57;
      default: base = 8'h00;
    endcase
    if (key_idx <= 4'd7) begin
      return base + {6'd0, tap};
    end else if (key_idx == 4'd8) begin
      return ASCII_SP;
    end else begin
      unique case (tap)
        2'd0: return 8'h2E;
        2'd1: return 8'h2C;
        2'd2: return 8'h3F;
        default: return 8'h21;
      endcase
    end
  endfunction

  function automatic logic [2:0] key_count(input logic [3:0] key_idx);
    unique case (key_idx)
      4'd5, 4'd7, 4'd9: return 3'd4;
      4'd8: return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  // Only letters shift; space, punctuation and backspace pass through.
  function automatic logic [7:0] apply_case(input logic [7:0] c, input logic lower);
    if (lower && c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/multitap_encoder_sync_fifo.sv
// Synchronous FIFO with registered head; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rptr_q];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/multitap_encoder.sv
// Multi-tap keypad text entry: key taps to committed ASCII in an output FIFO.
// Optional lowercase toggle input is enabled by defining MULTITAP_CASE_EN.
module multitap_encoder
  import multitap_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 8,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [NUM_KEYS-1:0]           key,
  input  logic                          btn_confirm,
  input  logic                          btn_back,
`ifdef MULTITAP_CASE_EN
  input  logic                          case_toggle,
`endif
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    preview_char,
  output logic                          preview_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  state_e     state_q, state_d;
  logic [3:0] cur_q, cur_d;
  logic [1:0] tap_q, tap_d;
  logic [7:0] timer_q, timer_d;
  logic       key_any_q, confirm_q, back_q, overflow_q;
  logic       press, confirm_ev, back_ev;
  logic [3:0] new_idx;
  logic [7:0] cur_char, push_data;
  logic       push, fifo_full, fifo_empty, fifo_pop;
  logic       lower;

`ifdef MULTITAP_CASE_EN
  logic case_q, lower_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      case_q  <= 1'b0;
      lower_q <= 1'b0;
    end else begin
      case_q <= case_toggle;
      if (case_toggle && !case_q) lower_q <= ~lower_q;
    end
  end
  assign lower = lower_q;
`else
  assign lower = 1'b0;
`endif

  assign press      = (|key) & ~key_any_q;
  assign confirm_ev = btn_confirm & ~confirm_q;
  assign back_ev    = btn_back & ~back_q;

  always_comb begin
    new_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key[i]) new_idx = 4'(i);
    end
  end

  assign cur_char       = apply_case(key_char(cur_q, tap_q), lower);
  assign preview_active = (state_q == StCompose);
  assign preview_char   = preview_active ? cur_char : 8'h00;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tap_d     = tap_q;
    timer_d   = timer_q;
    push      = 1'b0;
    push_data = cur_char;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StCompose;
          cur_d   = new_idx;
          tap_d   = '0;
          timer_d = '0;
        end else if (back_ev) begin
          push      = 1'b1;
          push_data = ASCII_BS;
        end
      end
      StCompose: begin
        if (press) begin
          timer_d = '0;
          if (new_idx == cur_q) begin
            tap_d = ({1'b0, tap_q} + 3'd1 == key_count(cur_q)) ? 2'd0 : tap_q + 2'd1;
          end else begin
            // Commit the old character and start the new key in one cycle.
            push  = 1'b1;
            cur_d = new_idx;
            tap_d = '0;
          end
        end else if (back_ev) begin
          state_d = StIdle;
        end else if (confirm_ev) begin
          push    = 1'b1;
          state_d = StIdle;
        end else if (tick) begin
          if (timer_q == 8'(TIMEOUT_TICKS - 1)) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      tap_q      <= '0;
      timer_q    <= '0;
      key_any_q  <= 1'b0;
      confirm_q  <= 1'b0;
      back_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tap_q     <= tap_d;
      timer_q   <= timer_d;
      key_any_q <= |key;
      confirm_q <= btn_confirm;
      back_q    <= btn_back;
      if (push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  assign fifo_pop  = out_ready & ~fifo_empty;
  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
